// File: rtl/window_seq_pkg.sv
// Shared types and helpers for the window sequencer: FSM state, default geometry,
// and the top-border lane mask.
package window_seq_pkg;

    typedef enum logic [1:0] {IDLE, FILL, RUN, FLUSH} state_t;

    localparam int DEF_LINES = 4;
    localparam int DEF_DELAY = DEF_LINES / 2;

    function automatic int delay_of(int lines);
        return lines / 2;
    endfunction

    // Row counter runs past the frame by DELAY rows while flushing.
    function automatic int row_cnt_w(int height, int lines);
        return $clog2(height + lines / 2 + 1);
    endfunction

    // Lane k sources row (newest - k); it is outside the frame when that is negative.
    function automatic logic lane_masked(int newest_row, int k);
        return newest_row < k;
    endfunction

endpackage

// File: rtl/line_buffer_en.sv
// Tapped line buffer: each write shifts one column down through LINES stored rows.
// The column pointer wraps on its own and only needs to stay consistent between rows.
module line_buffer_en #(
    parameter int BITS  = 8,
    parameter int WIDTH = 480,
    parameter int LINES = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  we,
    input  logic [BITS-1:0]       din,
    output logic [BITS*LINES-1:0] taps
);
    localparam int PTR_W = $clog2(WIDTH);

    logic [PTR_W-1:0] ptr;
    logic [BITS-1:0]  mem [LINES][WIDTH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            ptr <= '0;
        else if (we)
            ptr <= (ptr == PTR_W'(WIDTH - 1)) ? '0 : ptr + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (we) begin
            mem[0][ptr] <= din;
            for (int k = 1; k < LINES; k++)
                mem[k][ptr] <= mem[k-1][ptr];
        end
    end

    // Taps read the old column before this cycle's write lands.
    always_comb begin
        taps = '0;
        for (int k = 0; k < LINES; k++)
            taps[k*BITS +: BITS] = mem[k][ptr];
    end

endmodule

// File: rtl/window_sequencer.sv
// Sequences a tapped line buffer for window operators: tracks raster position,
// masks rows above the frame and flushes the bottom rows with injected zeros.
module window_sequencer
    import window_seq_pkg::*;
#(
    parameter int BITS   = 8,
    parameter int WIDTH  = 480,
    parameter int HEIGHT = 272,
    parameter int LINES  = 4
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic                        in_sof,
    input  logic [BITS-1:0]             in_data,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [BITS*(LINES+1)-1:0]   out_rows,
    output logic [$clog2(WIDTH)-1:0]    out_col,
    output logic [$clog2(HEIGHT)-1:0]   out_row,
    output logic                        out_eof,
    output logic                        busy,
    output logic                        sync_err
);
    localparam int DELAY  = delay_of(LINES);
    localparam int COL_W  = $clog2(WIDTH);
    localparam int ROW_W  = row_cnt_w(HEIGHT, LINES);
    localparam int OROW_W = $clog2(HEIGHT);

    state_t                    state;
    logic [COL_W-1:0]          col;
    logic [ROW_W-1:0]          row;
    logic                      stage_free, accept, sof_acc, inject, push, slice, last_col;
    logic [COL_W-1:0]          pcol;
    logic [ROW_W-1:0]          prow;
    logic [BITS-1:0]           push_data;
    logic [BITS*LINES-1:0]     taps;
    logic [BITS*(LINES+1)-1:0] lanes;

    line_buffer_en #(.BITS(BITS), .WIDTH(WIDTH), .LINES(LINES)) u_lb (
        .clk   (clk),
        .rst_n (rst_n),
        .we    (push),
        .din   (push_data),
        .taps  (taps)
    );

    // col/row hold the position the next push will take; sof overrides to (0,0).
    always_comb begin
        stage_free = !out_valid || out_ready;
        in_ready   = (state == IDLE) || ((state == FILL || state == RUN) && stage_free);
        accept     = in_valid && in_ready;
        sof_acc    = accept && in_sof;
        inject     = (state == FLUSH) && stage_free;
        push       = (accept && (state != IDLE || in_sof)) || inject;
        push_data  = inject ? '0 : in_data;
        pcol       = sof_acc ? '0 : col;
        prow       = sof_acc ? '0 : row;
        last_col   = (pcol == COL_W'(WIDTH - 1));
        slice      = push && (int'(prow) >= DELAY);
        lanes      = '0;
        lanes[BITS-1:0] = push_data;
        for (int k = 1; k <= LINES; k++)
            lanes[k*BITS +: BITS] = lane_masked(int'(prow), k) ? '0 : taps[(k-1)*BITS +: BITS];
    end

    assign busy = (state != IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            col       <= '0;
            row       <= '0;
            out_valid <= 1'b0;
            out_rows  <= '0;
            out_col   <= '0;
            out_row   <= '0;
            out_eof   <= 1'b0;
            sync_err  <= 1'b0;
        end else begin
            sync_err <= sof_acc && (state == FILL || state == RUN);
            if (push) begin
                col <= last_col ? '0 : pcol + 1'b1;
                row <= last_col ? prow + 1'b1 : prow;
                if (last_col && DELAY > 0 && int'(prow) == HEIGHT - 1 + DELAY)
                    state <= IDLE;
                else if (last_col && int'(prow) == HEIGHT - 1)
                    state <= (DELAY == 0) ? IDLE : FLUSH;
                else if (last_col && int'(prow) == DELAY - 1)
                    state <= RUN;
                else if (sof_acc)
                    state <= (DELAY == 0) ? RUN : FILL;
            end
            // Output register: loads on a slice push, otherwise drains on out_ready.
            if (slice) begin
                out_valid <= 1'b1;
                out_rows  <= lanes;
                out_col   <= pcol;
                out_row   <= OROW_W'(int'(prow) - DELAY);
                out_eof   <= last_col && (int'(prow) == HEIGHT - 1 + DELAY);
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: doc/window_sequencer.md
# window_sequencer

Controller that sequences the tapped line buffer for neighbourhood (window) operators in the ISP pipeline. It accepts a raster pixel stream with valid/ready handshake and advances the line buffer only on accepted pixels. It tracks column/row position, zero-masks rows outside the frame, and injects zero rows at end of frame to flush the bottom rows. It emits one (LINES+1)-row column slice per output pixel, centred on the output row, to the downstream window operator.

## Interface
- BITS, 8, pixel width
- WIDTH, 480, pixels per line
- HEIGHT, 272, lines per frame
- LINES, 4, line-buffer depth; must be even; window height = LINES+1; DELAY = LINES/2
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- in_valid  in  1  input pixel valid
- in_ready  out  1  input can be accepted
- in_sof  in  1  qualifies the accepted pixel as row 0, col 0
- in_data  in  BITS  input pixel
- out_valid  out  1  output slice valid
- out_ready  in  1  downstream accepts slice
- out_rows  out  BITS*(LINES+1)  lane k = pixel k rows above newest row, same column
- out_col  out  $clog2(WIDTH)  column of centre pixel
- out_row  out  $clog2(HEIGHT)  row of centre pixel (newest row − DELAY)
- out_eof  out  1  slice is row HEIGHT−1, col WIDTH−1
- busy  out  1  state ≠ IDLE
- sync_err  out  1  one-cycle pulse: in_sof accepted while not IDLE

## Operation
- States: IDLE, FILL, RUN, FLUSH. Position counters col (0..WIDTH−1) and row (0..HEIGHT−1+DELAY) track the newest pixel written.
- Accept = in_valid && in_ready. Push = accept, or flush injection in FLUSH. Each push writes one pixel (zero in FLUSH) into the line buffer and advances col, wrapping to 0 with row+1.
- IDLE: in_ready=1. Accepted pixels without in_sof are discarded. An accepted pixel with in_sof is pushed as (0,0). Next state is FILL, or RUN if DELAY=0.
- FILL: rows 0..DELAY−1 are pushed with no output. The push of (DELAY−1, WIDTH−1) moves the block to RUN.
- RUN: each push at newest row y produces one slice for centre row y−DELAY, column col. Lane k is forced to 0 when y−k<0, which covers the top border. The push of (HEIGHT−1, WIDTH−1) moves the block to FLUSH, or to IDLE if DELAY=0.
- FLUSH: in_ready=0. The block injects DELAY*WIDTH zero pushes, one per cycle when the output stage is free. Lanes whose source row is ≥HEIGHT are zero by construction. The injection producing out_eof moves the block to IDLE.
- Resync: in_sof accepted in FILL or RUN pulses sync_err and restarts at (0,0) with that pixel. Lanes from the aborted frame are masked by the row rule. In FLUSH, in_ready=0, so no sof is seen.
- Line-buffer contents are never cleared. Correctness relies only on masking.

## Timing
- Output stage is one register. A slice appears the cycle after its push.
- in_ready = (IDLE) || ((FILL||RUN) && (!out_valid || out_ready)). Flush injection uses the same gating.
- While out_valid && !out_ready, out_rows/out_col/out_row/out_eof are held stable.
- Full-rate throughput: one slice per clock with out_ready held high.
- Frame latency: first slice (row 0, col 0) appears 1 cycle after accepting input (DELAY, 0). Last slice appears 1 cycle after the final flush injection.
- Reset values: out_valid=0, out_rows=0, out_col=0, out_row=0, out_eof=0, busy=0, sync_err=0, state IDLE, counters 0. in_ready=1 after reset.
- Reset mid-frame returns to IDLE immediately. The next frame requires in_sof.

## Structure
- Package window_seq_pkg holds:
  - state enum
  - DELAY and counter-width localparams
  - a function computing the lane mask from row and k
- Sub-module line_buffer_en: LINES-deep tapped line buffer with write enable, a shared wrapping column pointer and BITS*LINES tap output. It is instantiated once. Lane 0 of out_rows is the pushed pixel itself.
- Controller FSM, counters and output register are in window_sequencer.

## Test plan
- Reset: assert rst_n low mid-RUN. All outputs return to reset values, in_ready=1, busy=0. Without in_sof no output follows.
- Full frame, WIDTH=8, HEIGHT=6, LINES=4, pixel = row*16+col, out_ready=1:
  - first out_valid arrives 1 cycle after accepting (2,0)
  - slice (0,3) has lanes {0x23,0x13,0x03,0,0}
  - exactly 48 slices, the last with out_eof
- Flush: in the same frame after (5,7), in_ready=0 for 16 cycles.
  - slice (5,7) has lanes {0,0,0x57,0x47,0x37}
  - busy falls the cycle after it is accepted
- Backpressure: drop out_ready randomly at 50%. The slice sequence is identical to the full-rate run, with no drops or duplicates, and outputs stay stable while stalled.
- Resync: in_sof at (3,4) of frame 1. sync_err pulses once, and the next frame's slices (0,x) have lanes 3–4 zero.
- IDLE drop: 10 pixels without in_sof are all accepted and produce no output. The following in_sof frame is correct.
